// File: rtl/mac_accumulator_if.sv
// rtl/mac_accumulator_if.sv - beat input and result output bundle of the MAC accumulator
interface mac_accumulator_if #(
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_cfg;
  logic                 in_clr;
  logic                 in_last;
  logic [ACC_WIDTH-1:0] in0;
  logic [ACC_WIDTH-1:0] in1;
  logic [ACC_WIDTH-1:0] in2;
  logic [ACC_WIDTH-1:0] in3;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out0;
  logic [ACC_WIDTH-1:0] out1;
  logic [ACC_WIDTH-1:0] out2;
  logic [ACC_WIDTH-1:0] out3;
  logic [1:0]           out_cfg;
  logic [CNT_WIDTH-1:0] out_count;

  modport master (
    output in_valid, in_cfg, in_clr, in_last, in0, in1, in2, in3, out_ready,
    input  in_ready, out_valid, out0, out1, out2, out3, out_cfg, out_count
  );

  modport slave (
    input  in_valid, in_cfg, in_clr, in_last, in0, in1, in2, in3, out_ready,
    output in_ready, out_valid, out0, out1, out2, out3, out_cfg, out_count
  );
endinterface

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - running sum of combiner lanes with cfg-dependent carry chaining
module mac_accumulator #(
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  mac_accumulator_if.slave bus
);
  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                         state_q, state_d;
  logic [3:0][ACC_WIDTH-1:0]      acc_q, acc_d, out_q, out_d;
  logic [3:0][ACC_WIDTH-1:0]      in_lane, base, sum;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d, cnt_new, out_cnt_q, out_cnt_d;
  logic [1:0]                     cfg_q, cfg_d, cfg_eff, out_cfg_q, out_cfg_d;
  logic                           out_valid_q, out_valid_d;
  logic                           fire, first, chain, quad;

  assign in_lane      = {bus.in3, bus.in2, bus.in1, bus.in0};
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign fire         = bus.in_valid && bus.in_ready;
  assign first        = fire && (state_q == IDLE || bus.in_clr);
  assign cfg_eff      = first ? bus.in_cfg : cfg_q;
  assign chain        = (cfg_eff == 2'b01) || (cfg_eff == 2'b10);
  assign quad         = (cfg_eff == 2'b10);
  assign base         = first ? '0 : acc_q;
  assign cnt_new      = first ? CNT_WIDTH'(1) :
                        (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  // Carry enters lanes 1 and 3 in dual or quad, lane 2 only in quad.
  always_comb begin
    logic c;
    c   = 1'b0;
    sum = '0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2)
        c = c & quad;
      else
        c = c & chain;
      {c, sum[k]} = {1'b0, base[k]} + {1'b0, in_lane[k]} + {{ACC_WIDTH{1'b0}}, c};
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    cfg_d       = cfg_q;
    out_d       = out_q;
    out_cfg_d   = out_cfg_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    if (fire) begin
      cfg_d = cfg_eff;
      if (bus.in_last) begin
        state_d     = IDLE;
        acc_d       = '0;
        cnt_d       = '0;
        out_d       = sum;
        out_cfg_d   = cfg_eff;
        out_cnt_d   = cnt_new;
        out_valid_d = 1'b1;
      end else begin
        state_d = ACCUM;
        acc_d   = sum;
        cnt_d   = cnt_new;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      cfg_q       <= '0;
      out_q       <= '0;
      out_cfg_q   <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
      out_q       <= out_d;
      out_cfg_q   <= out_cfg_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out0      = out_q[0];
  assign bus.out1      = out_q[1];
  assign bus.out2      = out_q[2];
  assign bus.out3      = out_q[3];
  assign bus.out_cfg   = out_cfg_q;
  assign bus.out_count = out_cnt_q;
  assign bus.out_valid = out_valid_q;
endmodule
